// File: rtl/vsu_op_requester_if.sv
`default_nettype none
// ============================================================================
//  Module   : vsu_op_requester_if
//  Purpose  : Bundles the store-request handshake, the per-lane VRF read
//             request/grant bus, credit returns and completion status of the
//             VSU operand requester.
//  Modports : slave  - the requester itself (accepts store requests, drives
//                      lane read requests and status).
//             master - the environment (issues store requests, grants reads,
//                      returns credits, observes status).
//  Signals  : req_valid_i/req_ready_o/req_vs_i/req_vlB_i/req_insn_id_i,
//             rd_req_o/rd_vreg_o/rd_idx_o/rd_gnt_i, op_pop_i,
//             busy_o/done_o/done_insn_id_o (suffixes seen from the requester)
//  Revision : 1.0 - initial release
// ============================================================================
interface vsu_op_requester_if #(
   parameter int unsigned NrLane = 4,
   parameter int unsigned VlenW  = 16,
   parameter int unsigned IdW    = 3
);
   // store request
   logic                      req_valid_i;
   logic                      req_ready_o;
   logic [4:0]                req_vs_i;
   logic [VlenW-1:0]          req_vlB_i;
   logic [IdW-1:0]            req_insn_id_i;
   // lane reads
   logic [NrLane-1:0]         rd_req_o;
   logic [4:0]                rd_vreg_o;
   logic [NrLane*VlenW-1:0]   rd_idx_o;
   logic [NrLane-1:0]         rd_gnt_i;
   // credits and status
   logic [NrLane-1:0]         op_pop_i;
   logic                      busy_o;
   logic                      done_o;
   logic [IdW-1:0]            done_insn_id_o;

   modport slave (
      input  req_valid_i, req_vs_i, req_vlB_i, req_insn_id_i, rd_gnt_i, op_pop_i,
      output req_ready_o, rd_req_o, rd_vreg_o, rd_idx_o, busy_o, done_o, done_insn_id_o
   );

   modport master (
      output req_valid_i, req_vs_i, req_vlB_i, req_insn_id_i, rd_gnt_i, op_pop_i,
      input  req_ready_o, rd_req_o, rd_vreg_o, rd_idx_o, busy_o, done_o, done_insn_id_o
   );
endinterface
`default_nettype wire

// File: rtl/vsu_op_requester.sv
`default_nettype none
// ============================================================================
//  Module   : vsu_op_requester
//  Purpose  : Turns a vector store instruction into per-lane VRF word reads.
//             Each lane reads words 0..N-1 (N = ceil(vlB / row bytes)) of the
//             source register, throttled by a per-lane credit counter that
//             mirrors free space in the VSU operand FIFO. Lanes advance
//             independently; completion is signalled once all lanes issued N.
//  Ports    : clk_i  - clock
//             rst_ni - asynchronous active-low reset
//             bus    - vsu_op_requester_if.slave (request, reads, credits,
//                      status)
//  Revision : 1.0 - initial release
// ============================================================================
module vsu_op_requester #(
   parameter int unsigned NrLane      = 4,
   parameter int unsigned WordB       = 8,
   parameter int unsigned CreditDepth = 4,
   parameter int unsigned VlenW       = 16,
   parameter int unsigned IdW         = 3
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   vsu_op_requester_if.slave   bus
);

   localparam int unsigned RowB    = NrLane * WordB;
   localparam int unsigned CreditW = $clog2(CreditDepth + 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;

   logic [0:0]        r_state;
   logic [4:0]        r_vs;
   logic [VlenW-1:0]  r_n;
   logic [IdW-1:0]    r_id;

   logic [VlenW-1:0]  w_vlb_round;
   logic [VlenW-1:0]  w_n;
   logic [NrLane-1:0] w_lane_done;
   logic [NrLane-1:0] w_rd_req;
   logic [NrLane-1:0] w_fire;
   logic              w_issue;
   logic              w_complete;
   logic              w_ready;
   logic              w_accept;

   // Word count wraps in VlenW bits, like the rest of the length datapath.
   assign w_vlb_round = bus.req_vlB_i + VlenW'(RowB - 1);
   assign w_n         = w_vlb_round / VlenW'(RowB);

   assign w_issue    = (r_state == ST_ISSUE);
   // Completion looks only at registered counters, so the cycle after the
   // last grant is the completion cycle (and N=0 completes immediately).
   assign w_complete = w_issue && (&w_lane_done);
   assign w_ready    = (r_state == ST_IDLE) || w_complete;
   assign w_accept   = bus.req_valid_i && w_ready;

   assign bus.req_ready_o    = w_ready;
   assign bus.rd_req_o       = w_rd_req;
   assign bus.rd_vreg_o      = r_vs;
   assign bus.busy_o         = w_issue;
   assign bus.done_o         = w_complete;
   assign bus.done_insn_id_o = r_id;

   for (genvar i = 0; i < NrLane; i++) begin : g_lane
      logic [VlenW-1:0]   r_issued;
      logic [CreditW-1:0] r_credit;

      assign w_lane_done[i] = (r_issued == r_n);
      assign w_rd_req[i]    = w_issue && (r_issued < r_n) && (r_credit != '0);
      // A grant without a request has no effect.
      assign w_fire[i]      = w_rd_req[i] && bus.rd_gnt_i[i];
      assign bus.rd_idx_o[i*VlenW +: VlenW] = r_issued;

      // Acceptance never coincides with a fire: it happens in IDLE or in the
      // completion cycle, where no lane is requesting.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_issued <= '0;
         end else if (w_accept) begin
            r_issued <= '0;
         end else if (w_fire[i]) begin
            r_issued <= r_issued + VlenW'(1);
         end
      end

      // Credits survive instruction boundaries; only reset reloads them.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_credit <= CreditW'(CreditDepth);
         end else begin
            case ({bus.op_pop_i[i], w_fire[i]})
               2'b10: if (r_credit != CreditW'(CreditDepth)) r_credit <= r_credit + CreditW'(1);
               2'b01: r_credit <= r_credit - CreditW'(1);
               default: r_credit <= r_credit;
            endcase
         end
      end

      a_credit_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
         !(bus.op_pop_i[i] && !w_fire[i] && (r_credit == CreditW'(CreditDepth))));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
      end else if (w_accept) begin
         r_state <= ST_ISSUE;
      end else if (w_complete) begin
         r_state <= ST_IDLE;
      end
   end

   // Instruction context needs no reset: it is only observed in ISSUE.
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_vs <= bus.req_vs_i;
         r_n  <= w_n;
         r_id <= bus.req_insn_id_i;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vsu_op_requester.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vsu_op_requester
//  Purpose  : Self-checking bench for vsu_op_requester. Accepted requests
//             push the expected per-lane read stream and completion id into
//             scoreboard queues; a negedge monitor pops and compares them as
//             reads are granted and done_o pulses. Cycle-exact timing points
//             are checked directly from the stimulus thread.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vsu_op_requester;

   localparam int unsigned NrLane      = 4;
   localparam int unsigned WordB       = 8;
   localparam int unsigned CreditDepth = 4;
   localparam int unsigned VlenW       = 16;
   localparam int unsigned IdW         = 3;
   localparam int unsigned RowB        = NrLane * WordB;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vsu_op_requester_if #(.NrLane(NrLane), .VlenW(VlenW), .IdW(IdW)) bus ();

   vsu_op_requester #(
      .NrLane(NrLane), .WordB(WordB), .CreditDepth(CreditDepth),
      .VlenW(VlenW), .IdW(IdW)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   logic echo = 1'b0;

   logic [31:0]    exp_rd_q [NrLane][$];
   logic [IdW-1:0] exp_done_q [$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] rd_entry(input logic [4:0] vs, input logic [VlenW-1:0] idx);
      logic [31:0] e;
      e = '0;
      e[VlenW +: 5]  = vs;
      e[VlenW-1:0]   = idx;
      return e;
   endfunction

   // Expected reads for a newly accepted instruction, derived from vlB.
   task automatic push_expected();
      int n;
      n = (int'(bus.req_vlB_i) + RowB - 1) / RowB;
      for (int i = 0; i < NrLane; i++)
         for (int k = 0; k < n; k++)
            exp_rd_q[i].push_back(rd_entry(bus.req_vs_i, VlenW'(k)));
      exp_done_q.push_back(bus.req_insn_id_i);
   endtask

   task automatic flush_expected();
      for (int i = 0; i < NrLane; i++) exp_rd_q[i].delete();
      exp_done_q.delete();
   endtask

   task automatic send(input logic [4:0] vs, input logic [VlenW-1:0] vlb, input logic [IdW-1:0] id);
      bus.req_vs_i      = vs;
      bus.req_vlB_i     = vlb;
      bus.req_insn_id_i = id;
      bus.req_valid_i   = 1'b1;
   endtask

   // Advance one cycle; returns 1 time unit after the rising edge.
   task automatic step();
      logic [NrLane-1:0] f;
      logic acc;
      @(negedge clk);
      f   = bus.rd_req_o & bus.rd_gnt_i;
      acc = bus.req_valid_i && bus.req_ready_o && rst_n;
      if (acc) push_expected();
      @(posedge clk);
      #1;
      if (acc) bus.req_valid_i = 1'b0;
      bus.op_pop_i = echo ? f : '0;
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (!bus.done_o && k < budget) begin
         step();
         k++;
      end
      check_eq("done_within_budget", bus.done_o, 1'b1);
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < NrLane; i++) begin
            if (bus.rd_req_o[i] && bus.rd_gnt_i[i]) begin
               if (exp_rd_q[i].size() == 0)
                  check_eq($sformatf("unexpected_read_lane%0d", i), 1, 0);
               else
                  check_eq($sformatf("rd_lane%0d", i),
                           rd_entry(bus.rd_vreg_o, bus.rd_idx_o[i*VlenW +: VlenW]),
                           exp_rd_q[i].pop_front());
            end
         end
         if (bus.done_o) begin
            if (exp_done_q.size() == 0)
               check_eq("unexpected_done", 1, 0);
            else
               check_eq("done_id", bus.done_insn_id_o, exp_done_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int left;
      bus.req_valid_i   = 1'b0;
      bus.req_vs_i      = '0;
      bus.req_vlB_i     = '0;
      bus.req_insn_id_i = '0;
      bus.rd_gnt_i      = '0;
      bus.op_pop_i      = '0;

      // ---- reset values
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ready", bus.req_ready_o, 1'b1);
      check_eq("rst_rd_req", bus.rd_req_o, '0);
      check_eq("rst_done", bus.done_o, 1'b0);
      check_eq("rst_busy", bus.busy_o, 1'b0);
      rst_n = 1'b1;
      step();

      // ---- vlB=64, grants tied high, pops echo grants
      bus.rd_gnt_i = '1;
      echo = 1'b1;
      send(5'd3, 16'd64, 3'd1);
      step();
      check_eq("s1_t1_rd_req", bus.rd_req_o, 4'hF);
      check_eq("s1_t1_idx0", bus.rd_idx_o[0 +: VlenW], 0);
      check_eq("s1_t1_busy", bus.busy_o, 1'b1);
      check_eq("s1_t1_ready", bus.req_ready_o, 1'b0);
      step();
      check_eq("s1_t2_rd_req", bus.rd_req_o, 4'hF);
      check_eq("s1_t2_idx3", bus.rd_idx_o[3*VlenW +: VlenW], 1);
      step();
      check_eq("s1_t3_done", bus.done_o, 1'b1);
      check_eq("s1_t3_rd_req", bus.rd_req_o, '0);
      check_eq("s1_t3_ready", bus.req_ready_o, 1'b1);
      step();
      check_eq("s1_t4_busy", bus.busy_o, 1'b0);
      check_eq("s1_t4_done", bus.done_o, 1'b0);
      step();

      // ---- vlB=256 (N=8), no pops: credits run out after idx 3
      echo = 1'b0;
      send(5'd5, 16'd256, 3'd2);
      repeat (4) step();
      check_eq("s2_t4_idx1", bus.rd_idx_o[1*VlenW +: VlenW], 3);
      step();
      check_eq("s2_t5_rd_req", bus.rd_req_o, '0);
      check_eq("s2_t5_busy", bus.busy_o, 1'b1);
      bus.op_pop_i = 4'b0001;
      step();
      check_eq("s2_t6_rd_req", bus.rd_req_o, 4'b0001);
      check_eq("s2_t6_idx0", bus.rd_idx_o[0 +: VlenW], 4);
      step();
      check_eq("s2_t7_rd_req", bus.rd_req_o, '0);
      // One credit back to every lane, then echo; each lane ends holding 1.
      echo = 1'b1;
      bus.op_pop_i = 4'hF;
      wait_done(40);
      step();
      echo = 1'b0;
      for (int r = 0; r < 3; r++) begin
         bus.op_pop_i = 4'hF;
         step();
      end

      // ---- vlB=33 -> N=2, vlB=32 -> N=1
      echo = 1'b1;
      send(5'd1, 16'd33, 3'd3);
      step();
      check_eq("s3a_t1_rd_req", bus.rd_req_o, 4'hF);
      step();
      check_eq("s3a_t2_idx2", bus.rd_idx_o[2*VlenW +: VlenW], 1);
      step();
      check_eq("s3a_t3_done", bus.done_o, 1'b1);
      step();
      send(5'd2, 16'd32, 3'd4);
      step();
      check_eq("s3b_t1_rd_req", bus.rd_req_o, 4'hF);
      step();
      check_eq("s3b_t2_done", bus.done_o, 1'b1);
      check_eq("s3b_t2_rd_req", bus.rd_req_o, '0);
      step();

      // ---- vlB=0: done next cycle, never a read
      send(5'd4, 16'd0, 3'd5);
      check_eq("s4_t0_busy", bus.busy_o, 1'b0);
      step();
      check_eq("s4_t1_done", bus.done_o, 1'b1);
      check_eq("s4_t1_busy", bus.busy_o, 1'b1);
      check_eq("s4_t1_rd_req", bus.rd_req_o, '0);
      step();
      check_eq("s4_t2_busy", bus.busy_o, 1'b0);
      check_eq("s4_t2_done", bus.done_o, 1'b0);

      // ---- back-to-back: next request taken in the completion cycle
      send(5'd6, 16'd32, 3'd6);
      step();
      send(5'd7, 16'd64, 3'd7);
      step();
      check_eq("s5_t2_done", bus.done_o, 1'b1);
      check_eq("s5_t2_ready", bus.req_ready_o, 1'b1);
      step();
      check_eq("s5_t3_busy", bus.busy_o, 1'b1);
      check_eq("s5_t3_rd_req", bus.rd_req_o, 4'hF);
      check_eq("s5_t3_vreg", bus.rd_vreg_o, 5'd7);
      check_eq("s5_t3_idx0", bus.rd_idx_o[0 +: VlenW], 0);
      wait_done(10);
      step();
      step();

      // ---- reset in the middle of an instruction
      echo = 1'b0;
      bus.rd_gnt_i = 4'b0101;
      send(5'd8, 16'd128, 3'd3);
      step();
      step();
      bus.rd_gnt_i = '0;
      check_eq("s6_pre_idx2", bus.rd_idx_o[2*VlenW +: VlenW], 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("s6_rst_rd_req", bus.rd_req_o, '0);
      check_eq("s6_rst_done", bus.done_o, 1'b0);
      check_eq("s6_rst_busy", bus.busy_o, 1'b0);
      check_eq("s6_rst_ready", bus.req_ready_o, 1'b1);
      flush_expected();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.rd_gnt_i = '1;
      // Four back-to-back reads per lane only work if credits were reloaded.
      send(5'd9, 16'd128, 3'd1);
      step();
      check_eq("s6_t1_rd_req", bus.rd_req_o, 4'hF);
      check_eq("s6_t1_idx2", bus.rd_idx_o[2*VlenW +: VlenW], 0);
      repeat (3) step();
      check_eq("s6_t4_rd_req", bus.rd_req_o, 4'hF);
      check_eq("s6_t4_idx0", bus.rd_idx_o[0 +: VlenW], 3);
      step();
      check_eq("s6_t5_done", bus.done_o, 1'b1);
      step();
      for (int r = 0; r < 4; r++) begin
         bus.op_pop_i = 4'hF;
         step();
      end
      repeat (2) step();

      left = exp_done_q.size();
      for (int i = 0; i < NrLane; i++) left += exp_rd_q[i].size();
      check_eq("scoreboard_drained", left, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vsu_op_requester.md
VSU_OP_REQUESTER -- requirements
Module: vsu_op_requester

Interface
- REQ-001 SHALL provide parameters:
  - NrLane, default 4, number of lanes.
  - WordB, default 8, bytes per lane VRF word.
  - CreditDepth, default 4, per-lane VSU operand FIFO depth.
  - VlenW, default 16, width of byte-length and word-index fields.
  - IdW, default 3, instruction id width.
- REQ-002 SHALL have one clock and an asynchronous, active-low reset. Ports are listed as name, direction, width, meaning:
  - clk_i  in  1  clock.
  - rst_ni  in  1  asynchronous active-low reset.
- REQ-003 Store-request ports:
  - req_valid_i  in  1  store instruction request valid.
  - req_ready_o  out  1  request accepted when high with req_valid_i.
  - req_vs_i  in  5  source vector register.
  - req_vlB_i  in  VlenW  byte length.
  - req_insn_id_i  in  IdW  instruction id.
- REQ-004 Lane read-request ports:
  - rd_req_o  out  NrLane  per-lane VRF read request.
  - rd_vreg_o  out  5  register read; common to all lanes.
  - rd_idx_o  out  NrLane*VlenW  per-lane word index.
  - rd_gnt_i  in  NrLane  per-lane grant; a read is issued when rd_req_o[i] and rd_gnt_i[i] are both high.
- REQ-005 Status and completion ports:
  - op_pop_i  in  NrLane  VSU popped one word from lane i's FIFO (credit return).
  - busy_o  out  1  an instruction is in progress.
  - done_o  out  1  one-cycle completion pulse.
  - done_insn_id_o  out  IdW  id of the completing instruction.

Function
- REQ-006 SHALL implement states IDLE and ISSUE.
- REQ-007 SHALL compute per-instruction word count N = ceil(vlB / (NrLane*WordB)) at acceptance, in VlenW-bit arithmetic. Every lane reads exactly N words, indices 0..N-1, in order.
- REQ-008 IDLE:
  - req_ready_o=1, rd_req_o=0, busy_o=0.
  - On req_valid_i: latch vs, N and id; clear all per-lane issued counters; go to ISSUE.
- REQ-009 ISSUE, per lane i:
  - rd_req_o[i] = (issued[i] < N) AND (credit[i] > 0).
  - rd_idx_o[i] = issued[i].
  - rd_vreg_o = latched vs; busy_o=1.
- REQ-010 On rd_req_o[i] AND rd_gnt_i[i]: issued[i]++ and credit[i]--. A grant without a request SHALL be ignored.
- REQ-011 Credit counters:
  - width clog2(CreditDepth+1); reset to CreditDepth.
  - op_pop_i[i] increments credit[i].
  - A grant and a pop on the same lane in the same cycle leave credit[i] unchanged.
  - A pop at credit==CreditDepth SHALL saturate and fire a simulation assertion.
- REQ-012 Credits SHALL persist across instruction boundaries; they are never reloaded except by reset.
- REQ-013 Lanes SHALL advance independently; no lane waits for another.
- REQ-014 Completion is the first ISSUE cycle in which all issued[i]==N (registered values). In that cycle:
  - done_o=1 and done_insn_id_o = latched id.
  - req_ready_o=1.
  - If req_valid_i is high, load the new request and stay in ISSUE (no bubble); otherwise go to IDLE.
- REQ-015 Request acceptance to first rd_req_o SHALL take exactly one cycle when credit is available.
- REQ-016 vlB=0 gives N=0: accept at cycle T, done_o at T+1, no rd_req_o ever asserted.
- REQ-017 done_o SHALL be 0 in every cycle other than a completion cycle. done_insn_id_o is don't-care when done_o=0.
- REQ-018 req_ready_o SHALL be 0 in ISSUE except in the completion cycle.

Reset
- REQ-019 Asynchronous reset SHALL force the following, at any time including mid-instruction:
  - state=IDLE, issued counters=0, credits=CreditDepth.
  - rd_req_o=0, done_o=0, busy_o=0, req_ready_o=1 (as soon as reset is asserted).
- REQ-020 Latched vs, N and id need not be reset.
- REQ-021 An instruction interrupted by reset SHALL NOT produce done_o.

Verification
- REQ-022 vlB=64, gnt tied 1, op_pop_i echoes grants one cycle later -> each lane issues idx 0,1 on cycles T+1,T+2; done_o at T+3 with correct id.
- REQ-023 vlB=256, gnt tied 1, no pops -> each lane issues idx 0..3, then rd_req_o drops. A single op_pop_i[0] -> lane 0 alone issues idx 4.
- REQ-024 vlB=33 -> N=2; vlB=32 -> N=1. Check rd_idx_o sequence and done timing.
- REQ-025 vlB=0 -> done_o at T+1, rd_req_o never high, busy_o high only at T+1.
- REQ-026 Second req_valid_i held during the completion cycle -> accepted the same cycle; first rd_req_o of the new instruction the next cycle; no IDLE cycle in between.
- REQ-027 Reset asserted with lane 2 at issued=1 of N=4 and credits partly consumed -> all outputs at reset values; credits=CreditDepth; no done_o; next request starts at idx 0.
